// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load and a shift-op word counter.
// The counter pulses DONE for one cycle each time WIDTH shift ops have run.
// A tap output reads any single bit of the register.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 3
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             ce_i,
    input  logic             sclr_i,
    input  logic [2:0]       mode_i,
    input  logic             si_r_i,
    input  logic             si_l_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [ADDRW-1:0] a_i,
    output logic [WIDTH-1:0] q_o,
    output logic             so_l_o,
    output logic             so_r_o,
    output logic             tap_o,
    output logic [ADDRW-1:0] cnt_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        MODE_HOLD0 = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_HOLD7 = 3'b111
    } mode_e;

    localparam logic [ADDRW-1:0] CntLast = ADDRW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             isShift;
    logic [WIDTH-1:0] tapShifted;

    // Next-state decode: synchronous clear beats the clock enable, which beats the mode.
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        isShift = 1'b0;
        if (sclr_i) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (ce_i) begin
            case (mode_e'(mode_i))
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], si_r_i};
                    isShift = 1'b1;
                end
                MODE_SHR: begin
                    q_d     = {si_l_i, q_q[WIDTH-1:1]};
                    isShift = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    isShift = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    isShift = 1'b1;
                end
                MODE_ASR: begin
                    q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    isShift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = d_i;
                    cnt_d = '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
            if (isShift) begin
                if (cnt_q == CntLast) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers; the active-low clear acts immediately, without a clock edge.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Tap select: addresses beyond the top bit read as zero.
    always_comb begin
        tapShifted = q_q >> a_i;
        tap_o      = 1'b0;
        if (32'(a_i) < WIDTH) begin
            tap_o = tapShifted[0];
        end
    end

    assign q_o    = q_q;
    assign so_l_o = q_q[WIDTH-1];
    assign so_r_o = q_q[0];
    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg: directed scenarios plus randomized traffic,
// scored against a behavioural model through an expectation queue.
module tb_univ_shift_reg;

    localparam int W    = 8;
    localparam int AW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          clrN;
    logic          ce;
    logic          sclr;
    logic [2:0]    mode;
    logic          siR;
    logic          siL;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [W-1:0]  q;
    logic          soL;
    logic          soR;
    logic          tap;
    logic [AW-1:0] cnt;
    logic          done;

    logic [2:0]    mode6;
    logic [5:0]    d6;
    logic [2:0]    a6;
    logic [5:0]    q6;
    logic          soL6;
    logic          soR6;
    logic          tap6;
    logic [2:0]    cnt6;
    logic          done6;

    int checks = 0;
    int fails  = 0;

    int unsigned mQ   = 0;
    int unsigned mCnt = 0;
    bit          mDone = 0;

    typedef struct {
        logic [W-1:0]  q;
        logic [AW-1:0] cnt;
        logic          done;
        logic          tap;
    } exp_t;

    exp_t sbQueue[$];

    univ_shift_reg #(.WIDTH(W), .ADDRW(AW)) dut (
        .clk_i(clk), .clr_n_i(clrN), .ce_i(ce), .sclr_i(sclr), .mode_i(mode),
        .si_r_i(siR), .si_l_i(siL), .d_i(d), .a_i(a),
        .q_o(q), .so_l_o(soL), .so_r_o(soR), .tap_o(tap), .cnt_o(cnt), .done_o(done)
    );

    univ_shift_reg #(.WIDTH(6), .ADDRW(3)) dut6 (
        .clk_i(clk), .clr_n_i(clrN), .ce_i(1'b1), .sclr_i(1'b0), .mode_i(mode6),
        .si_r_i(1'b0), .si_l_i(1'b0), .d_i(d6), .a_i(a6),
        .q_o(q6), .so_l_o(soL6), .so_r_o(soR6), .tap_o(tap6), .cnt_o(cnt6), .done_o(done6)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: advance one clock edge using the current input values.
    task automatic modelStep();
        bit shiftOp;
        shiftOp = 0;
        if (!clrN || sclr) begin
            mQ = 0; mCnt = 0; mDone = 0;
        end else if (!ce) begin
            mDone = 0;
        end else begin
            mDone = 0;
            case (mode)
                3'd1: begin mQ = ((mQ << 1) | siR) & MASK; shiftOp = 1; end
                3'd2: begin mQ = (mQ >> 1) + (siL ? (1 << (W - 1)) : 0); shiftOp = 1; end
                3'd3: begin mQ = ((mQ << 1) | (mQ >> (W - 1))) & MASK; shiftOp = 1; end
                3'd4: begin mQ = (mQ >> 1) + ((mQ % 2) << (W - 1)); shiftOp = 1; end
                3'd6: begin mQ = (mQ >> 1) + (mQ & (1 << (W - 1))); shiftOp = 1; end
                3'd5: begin mQ = d; mCnt = 0; end
                default: ;
            endcase
            if (shiftOp) begin
                mCnt  = (mCnt + 1) % W;
                mDone = (mCnt == 0);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input logic clrArg, input logic ceArg, input logic sclrArg,
                                 input logic [2:0] modeArg, input logic siRArg, input logic siLArg,
                                 input logic [W-1:0] dArg, input logic [AW-1:0] aArg);
        exp_t e;
        @(negedge clk);
        clrN = clrArg; ce = ceArg; sclr = sclrArg; mode = modeArg;
        siR = siRArg; siL = siLArg; d = dArg; a = aArg;
        modelStep();
        e.q    = W'(mQ);
        e.cnt  = AW'(mCnt);
        e.done = mDone;
        e.tap  = (int'(aArg) < W) ? logic'((mQ >> aArg) & 1) : 1'b0;
        sbQueue.push_back(e);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: each rising edge presents a new register state; pop and compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("sb_q",    32'(q),    32'(e.q));
                checkOutput("sb_cnt",  32'(cnt),  32'(e.cnt));
                checkOutput("sb_done", 32'(done), 32'(e.done));
                checkOutput("sb_so_l", 32'(soL),  32'(e.q[W-1]));
                checkOutput("sb_so_r", 32'(soR),  32'(e.q[0]));
                checkOutput("sb_tap",  32'(tap),  32'(e.tap));
            end
        end
    end

    // Main sequence: reset, directed scenarios, then randomized traffic.
    initial begin
        clrN = 1'b0; ce = 1'b0; sclr = 1'b0; mode = 3'd0; siR = 1'b0; siL = 1'b0;
        d = '0; a = '0; mode6 = 3'd0; d6 = '0; a6 = '0;
        #2;
        checkOutput("reset_q",    32'(q),    32'h0);
        checkOutput("reset_cnt",  32'(cnt),  32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);

        // Load then shift left
        applyStimulus(1, 1, 0, 3'd5, 0, 0, 8'hA5, 0);
        afterEdge();
        checkOutput("load_q",   32'(q),   32'hA5);
        checkOutput("load_cnt", 32'(cnt), 32'h0);
        applyStimulus(1, 1, 0, 3'd1, 1, 0, 0, 0);
        checkOutput("shl_so_l_before", 32'(soL), 32'h1);
        afterEdge();
        checkOutput("shl_q", 32'(q), 32'h4B);

        // Full word count from zero
        applyStimulus(1, 1, 1, 3'd0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1, 0, 3'd1, 1, 0, 0, 0);
            afterEdge();
            checkOutput("word_done", 32'(done), (i == 8) ? 32'h1 : 32'h0);
        end
        checkOutput("word_q",   32'(q),   32'hFF);
        checkOutput("word_cnt", 32'(cnt), 32'h0);
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0, 0);
        afterEdge();
        checkOutput("word_done_drop", 32'(done), 32'h0);

        // Rotate right, arithmetic right, rotate left
        applyStimulus(1, 1, 0, 3'd5, 0, 0, 8'h81, 0);
        applyStimulus(1, 1, 0, 3'd4, 0, 0, 0, 0);
        afterEdge();
        checkOutput("ror_q", 32'(q), 32'hC0);
        applyStimulus(1, 1, 0, 3'd6, 0, 0, 0, 0);
        afterEdge();
        checkOutput("asr_q", 32'(q), 32'hE0);
        applyStimulus(1, 1, 0, 3'd3, 0, 0, 0, 0);
        afterEdge();
        checkOutput("rol_q", 32'(q), 32'hC1);

        // Clock enable low holds, synchronous clear overrides it
        applyStimulus(1, 1, 0, 3'd5, 0, 0, 8'h0F, 0);
        applyStimulus(1, 1, 0, 3'd1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 3'd1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 3'd1, 1, 0, 0, 0);
        afterEdge();
        checkOutput("ce_hold_q",   32'(q),   32'h3C);
        checkOutput("ce_hold_cnt", 32'(cnt), 32'h2);
        applyStimulus(1, 0, 1, 3'd1, 1, 0, 0, 0);
        afterEdge();
        checkOutput("sclr_q",   32'(q),   32'h0);
        checkOutput("sclr_cnt", 32'(cnt), 32'h0);

        // Asynchronous clear mid-count
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 3'd1, 1, 0, 0, 0);
        afterEdge();
        checkOutput("pre_async_cnt", 32'(cnt), 32'h5);
        #1;
        clrN = 1'b0;
        mQ = 0; mCnt = 0; mDone = 0;
        #1;
        checkOutput("async_q",   32'(q),   32'h0);
        checkOutput("async_cnt", 32'(cnt), 32'h0);
        applyStimulus(0, 1, 0, 3'd5, 1, 1, 8'hFF, 0);
        afterEdge();
        checkOutput("async_hold_q", 32'(q), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1, 0, 3'd2, 1, 1, 0, 0);
            afterEdge();
            checkOutput("post_async_done", 32'(done), (i == 8) ? 32'h1 : 32'h0);
        end

        // Tap selection, including an out-of-range address on a narrower register
        applyStimulus(1, 1, 0, 3'd5, 0, 0, 8'h5A, 1);
        afterEdge();
        checkOutput("tap_a1", 32'(tap), 32'h1);
        a = 3'd0;
        #1;
        checkOutput("tap_a0", 32'(tap), 32'h0);
        a = 3'd6;
        #1;
        checkOutput("tap_a6", 32'(tap), 32'h1);
        @(negedge clk);
        mode6 = 3'd5; d6 = 6'h3F;
        @(negedge clk);
        mode6 = 3'd0; a6 = 3'd5;
        #1;
        checkOutput("tap6_a5", 32'(tap6), 32'h1);
        a6 = 3'd7;
        #1;
        checkOutput("tap6_a7", 32'(tap6), 32'h0);

        // Randomized traffic, with occasional clears of both kinds
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 150) != 0, ($urandom % 8) != 0, ($urandom % 20) == 0,
                          3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                          W'($urandom), AW'($urandom));
        end
        applyStimulus(1, 0, 0, 3'd0, 0, 0, 0, 0);
        afterEdge();
        afterEdge();
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
